// File: rtl/config_serializer.sv
// ---------------------------------------------------------------------------
// config_serializer
//   Transmit side of the generator's serial configuration interface. A single
//   parallel frame (dynamic word plus static word) is captured on an accepted
//   start. It is then shifted out MSB first on signal_out in this order:
//     DYN    (SIZESRDYN cycles,  SELDYN=1)
//     STAT   (SIZESRSTAT cycles, SELSTAT=1)
//     COMMIT (1 cycle,           SELDYN=1, signal_out=0)
//   The generator latches DYNLATCH on the first STAT cycle and STATLATCH on
//   COMMIT. Every output is a register.
//
// Ports
//   CLK, RST_N       clock (rising edge) / asynchronous active-low reset
//   start            frame request, only honoured in IDLE
//   abort            synchronous frame cancel; wins over start
//   dyn_in, stat_in  frame words, captured when start is accepted
//   busy             frame in progress (DYN/STAT/COMMIT)
//   done             one-cycle pulse on the cycle after a completed COMMIT
//   SELDYN, SELSTAT  generator select lines (never both high)
//   signal_out       serial data to the generator
// ---------------------------------------------------------------------------
module config_serializer #(
  parameter int SIZESRDYN  = 16,
  parameter int SIZESRSTAT = 88,
  parameter int CNTW       = 7
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SIZESRDYN-1:0]  dyn_in,
  input  logic [SIZESRSTAT-1:0] stat_in,
  output logic                  busy,
  output logic                  done,
  output logic                  SELDYN,
  output logic                  SELSTAT,
  output logic                  signal_out
);

  localparam int DW = (SIZESRDYN  > 1) ? $clog2(SIZESRDYN)  : 1;
  localparam int SW = (SIZESRSTAT > 1) ? $clog2(SIZESRSTAT) : 1;
  localparam logic [CNTW-1:0] DYN_LAST  = CNTW'(SIZESRDYN - 1);
  localparam logic [CNTW-1:0] STAT_LAST = CNTW'(SIZESRSTAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DYN    = 2'd1,
    ST_STAT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [SIZESRDYN-1:0]    dyn_sh_q, dyn_sh_d;
  logic [SIZESRSTAT-1:0]   stat_sh_q, stat_sh_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    seldyn_q, seldyn_d;
  logic                    selstat_q, selstat_d;
  logic                    sig_q, sig_d;
  logic [DW-1:0]           dyn_idx_s;
  logic [SW-1:0]           stat_idx_s;

  // Next-state, counter, shadow capture and next-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dyn_sh_d  = dyn_sh_q;
    stat_sh_d = stat_sh_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_DYN;
          cnt_d     = {CNTW{1'b0}};
          dyn_sh_d  = dyn_in;
          stat_sh_d = stat_in;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = {CNTW{1'b0}};
        end
      end
      ST_DYN: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = {CNTW{1'b0}};
        end else if (cnt_q == DYN_LAST) begin
          state_d = ST_STAT;
          cnt_d   = {CNTW{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
      end
      ST_STAT: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = {CNTW{1'b0}};
        end else if (cnt_q == STAT_LAST) begin
          state_d = ST_COMMIT;
          cnt_d   = {CNTW{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        cnt_d   = {CNTW{1'b0}};
        done_d  = !abort;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNTW{1'b0}};
      end
    endcase

    // Outputs are registered, so they are derived from the state being
    // entered. On the accepting edge dyn_sh_d already carries dyn_in.
    dyn_idx_s  = DW'(SIZESRDYN - 1)  - DW'(cnt_d);
    stat_idx_s = SW'(SIZESRSTAT - 1) - SW'(cnt_d);
    busy_d     = (state_d != ST_IDLE);
    seldyn_d   = (state_d == ST_DYN) || (state_d == ST_COMMIT);
    selstat_d  = (state_d == ST_STAT);

    case (state_d)
      ST_DYN:  sig_d = dyn_sh_d[dyn_idx_s];
      ST_STAT: sig_d = stat_sh_d[stat_idx_s];
      default: sig_d = 1'b0;
    endcase
  end

  // State, counter, shadow words and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNTW{1'b0}};
      dyn_sh_q  <= {SIZESRDYN{1'b0}};
      stat_sh_q <= {SIZESRSTAT{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      seldyn_q  <= 1'b0;
      selstat_q <= 1'b0;
      sig_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dyn_sh_q  <= dyn_sh_d;
      stat_sh_q <= stat_sh_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      seldyn_q  <= seldyn_d;
      selstat_q <= selstat_d;
      sig_q     <= sig_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign SELDYN     = seldyn_q;
  assign SELSTAT    = selstat_q;
  assign signal_out = sig_q;

endmodule

// File: tb/tb_config_serializer.sv
// ---------------------------------------------------------------------------
// tb_config_serializer
//   Bench for config_serializer. The reference is the number of cycles since
//   the frame was accepted; the expected outputs follow directly from that
//   number. A small generator receiver model is included so that the latched
//   words can be compared with literal values.
// ---------------------------------------------------------------------------
module tb_config_serializer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start;
  logic        abort;
  logic [15:0] dyn_in;
  logic [87:0] stat_in;
  logic        busy, done, SELDYN, SELSTAT, signal_out;

  int n_cmp = 0;
  int n_bad = 0;

  config_serializer #(.SIZESRDYN(16), .SIZESRSTAT(88), .CNTW(7)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
    .dyn_in(dyn_in), .stat_in(stat_in), .busy(busy), .done(done),
    .SELDYN(SELDYN), .SELSTAT(SELSTAT), .signal_out(signal_out)
  );

  always #5 CLK = ~CLK;

  // Reference: p = cycles since acceptance (0 idle, 1..105 frame, 106 done).
  int          p_q = 0;
  logic [15:0] mdyn_q = 16'h0;
  logic [87:0] mstat_q = 88'h0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_q <= 0;
    end else if (p_q >= 1 && p_q <= 105) begin
      p_q <= abort ? 0 : p_q + 1;
    end else if (start && !abort) begin
      p_q     <= 1;
      mdyn_q  <= dyn_in;
      mstat_q <= stat_in;
    end else begin
      p_q <= 0;
    end
  end

  // {busy, done, SELDYN, SELSTAT, signal_out} for frame position p
  function automatic logic [4:0] exp_out(int p, logic [15:0] d, logic [87:0] s);
    logic b, dn, sd, ss, so;
    b  = (p >= 1 && p <= 105);
    dn = (p == 106);
    sd = (p >= 1 && p <= 16) || (p == 105);
    ss = (p >= 17 && p <= 104);
    so = 1'b0;
    if (p >= 1 && p <= 16) so = d[16 - p];
    if (p >= 17 && p <= 104) so = s[104 - p];
    return {b, dn, sd, ss, so};
  endfunction

  // Generator receiver model: left-shifting registers and two latches.
  logic [15:0] rx_dyn_sr = 16'h0;
  logic [87:0] rx_stat_sr = 88'h0;
  logic [15:0] rx_dynlatch = 16'h0;
  logic [87:0] rx_statlatch = 88'h0;
  logic        rx_prev_sd = 1'b0;
  logic        rx_prev_ss = 1'b0;

  always @(posedge CLK) begin
    if (SELDYN) rx_dyn_sr <= {rx_dyn_sr[14:0], signal_out};
    if (SELSTAT) rx_stat_sr <= {rx_stat_sr[86:0], signal_out};
    if (!SELDYN && !SELSTAT) begin
      rx_dyn_sr  <= 16'h0;
      rx_stat_sr <= 88'h0;
    end
    if (SELSTAT && rx_prev_sd) rx_dynlatch <= rx_dyn_sr;
    if (SELDYN && rx_prev_ss) rx_statlatch <= rx_stat_sr;
    rx_prev_sd <= SELDYN;
    rx_prev_ss <= SELSTAT;
  end

  // Every-cycle comparison against the reference.
  initial begin
    logic [4:0] got, exp;
    forever begin
      @(negedge CLK);
      got = {busy, done, SELDYN, SELSTAT, signal_out};
      exp = exp_out(p_q, mdyn_q, mstat_q);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t p=%0d got=%b expected=%b", $time, p_q, got, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Drive a start at the current negedge, then wait (bounded) for done.
  task automatic run_frame(input logic [15:0] d, input logic [87:0] s, output int lat);
    start   = 1'b1;
    dyn_in  = d;
    stat_in = s;
    @(negedge CLK);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 300) begin
      dyn_in  = 16'($urandom);
      stat_in = {24'($urandom), 32'($urandom), 32'($urandom)};
      @(negedge CLK);
      lat++;
    end
    if (lat >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout got=none expected=done");
    end
  endtask

  initial begin
    int          lat, nd, nsd, nss;
    logic [15:0] v16;
    logic        b106;
    logic [87:0] rs;

    RST_N = 1'b0; start = 1'b0; abort = 1'b0; dyn_in = 16'h0; stat_in = 88'h0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("reset_idle", {123'h0, busy, done, SELDYN, SELSTAT, signal_out}, 128'h0);
    end

    // 2: full frame through the receiver
    run_frame(16'hABCD, 88'h123456789ABCDEF1234567, lat);
    chk("done_latency", 128'(lat), 128'd106);
    chk("dynlatch_abcd", 128'(rx_dynlatch), 128'h0ABCD);
    chk("statlatch", 128'(rx_statlatch), 128'h123456789ABCDEF1234567);
    repeat (3) @(negedge CLK);

    // 3: waveform for 16'h8001
    start = 1'b1; dyn_in = 16'h8001; stat_in = 88'h0F;
    nsd = 0; nss = 0; v16 = 16'h0;
    for (int i = 1; i <= 104; i++) begin
      @(negedge CLK);
      start = 1'b0;
      if (SELDYN) begin
        nsd++;
        v16 = {v16[14:0], signal_out};
      end
      if (SELSTAT) nss++;
    end
    chk("dyn_wave", 128'(v16), 128'h8001);
    chk("seldyn_len", 128'(nsd), 128'd16);
    chk("selstat_len", 128'(nss), 128'd88);
    repeat (4) @(negedge CLK);

    // 4: start pulses mid-frame ignored, start in done cycle accepted
    start = 1'b1; dyn_in = 16'h5A5A; stat_in = 88'hC3;
    nd = 0; b106 = 1'b1;
    for (int i = 1; i <= 106; i++) begin
      @(negedge CLK);
      start = (i == 5 || i == 50 || i == 104 || i == 106);
      if (done) nd++;
      if (i == 106) b106 = busy;
    end
    @(negedge CLK);
    start = 1'b0;
    chk("single_done", 128'(nd), 128'd1);
    chk("busy_drop_done", 128'(b106), 128'd0);
    chk("busy_second", 128'(busy), 128'd1);
    lat = 0;
    while (!done && lat < 300) begin
      @(negedge CLK);
      lat++;
    end
    chk("second_frame_done", 128'(done), 128'd1);
    chk("dynlatch_5a5a", 128'(rx_dynlatch), 128'h5A5A);
    repeat (3) @(negedge CLK);

    // 5: abort at STAT cycle 10, then a clean frame
    start = 1'b1; dyn_in = 16'h2468; stat_in = 88'h77;
    for (int i = 1; i <= 27; i++) begin
      @(negedge CLK);
      start = 1'b0;
      abort = (i == 27);
    end
    @(negedge CLK);
    abort = 1'b0;
    chk("abort_idle", {125'h0, busy, SELDYN, SELSTAT}, 128'h0);
    nd = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge CLK);
      if (done) nd++;
    end
    chk("abort_no_done", 128'(nd), 128'd0);
    run_frame(16'h1357, 88'hFEDCBA9876543210ABCDEF, lat);
    chk("dynlatch_1357", 128'(rx_dynlatch), 128'h1357);
    chk("statlatch_after_abort", 128'(rx_statlatch), 128'hFEDCBA9876543210ABCDEF);
    repeat (3) @(negedge CLK);

    // 6: reset during DYN cycle 7
    start = 1'b1; dyn_in = 16'hFFFF; stat_in = 88'h1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    #2 RST_N = 1'b0;
    #1 chk("async_reset", {123'h0, busy, done, SELDYN, SELSTAT, signal_out}, 128'h0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (done) nd++;
    end
    chk("reset_no_done", 128'(nd), 128'd0);
    rs = {24'($urandom), 32'($urandom), 32'($urandom)};
    run_frame(16'h0F0F, rs, lat);
    chk("dynlatch_0f0f", 128'(rx_dynlatch), 128'h0F0F);
    chk("statlatch_rand", 128'(rx_statlatch), 128'(rs));

    // Random traffic checked by the every-cycle reference
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 15) == 0);
      abort   = ($urandom_range(0, 199) == 0);
      dyn_in  = 16'($urandom);
      stat_in = {24'($urandom), 32'($urandom), 32'($urandom)};
      @(negedge CLK);
    end
    start = 1'b0; abort = 1'b0;
    repeat (110) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
